// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master that reads one DATA_W-bit ADC sample per start request.
// Define ADC_READER_OVERRUN_EN to keep the unconsumed sample and raise sticky overrun on sample loss.
module adc_spi_reader #(
  parameter int DATA_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sdo,
  output logic              cs_n,
  output logic              sclk,
  output logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * DATA_W + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              tick;
  logic              deliver;
  assign tick = div_q == DIV_W'(CLK_DIV - 1);
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    sclk_d    = sclk_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    data_d    = data_q;
    valid_d   = valid_q && !ready;
    overrun_d = overrun_q;
    deliver   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        div_d   = '0;
        cnt_d   = '0;
        shift_d = '0;
      end
      SETUP: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          cnt_d   = CNT_W'(1);
          shift_d = DATA_W'({shift_q, sdo});
        end
      end
      SHIFT: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (tick) begin
          sclk_d  = !sclk_q;
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = sclk_q ? shift_q : DATA_W'({shift_q, sdo});
          // cnt_q counts sclk toggles already made; this one is the final fall
          if (cnt_q == CNT_W'(2 * DATA_W - 1)) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            busy_d  = 1'b0;
            deliver = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (deliver) begin
      valid_d = 1'b1;
`ifdef ADC_READER_OVERRUN_EN
      if (valid_q && !ready) overrun_d = 1'b1;
      else data_d = shift_q;
`else
      data_d = shift_q;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign busy    = busy_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader: table-driven conversions with an expected-result queue, plus
// hand sequences for ignored start, mid-transfer reset, late ready and an 8-bit/CLK_DIV=1 instance.
module tb_adc_spi_reader;
`ifdef ADC_READER_OVERRUN_EN
  localparam logic OVR = 1'b1;
`else
  localparam logic OVR = 1'b0;
`endif
  typedef struct {
    logic [11:0] word;
    logic        rdy;
    logic [11:0] exp_data;
    logic        exp_ovr;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sdo = 1'b0;
  logic        ready = 1'b1;
  logic        cs_n, sclk, busy, valid, overrun;
  logic [11:0] data;
  logic        start8 = 1'b0;
  logic        cs_n8, sclk8, busy8, valid8, overrun8;
  logic [7:0]  data8;
  logic [11:0] adc_word = 12'h000;
  int          bitp = 0;
  int          checks = 0;
  int          errors = 0;
  int          low_cnt = 0;
  int          rise_cnt = 0;
  int          rise8_cnt = 0;
  logic        sclk_prev = 1'b0;
  logic        sclk8_prev = 1'b0;
  vec_t        exp_q[$];
  vec_t        vecs[6];
  adc_spi_reader u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sdo(sdo), .cs_n(cs_n), .sclk(sclk),
    .busy(busy), .data(data), .valid(valid), .ready(ready), .overrun(overrun)
  );
  adc_spi_reader #(.DATA_W(8), .CLK_DIV(1)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .sdo(1'b1), .cs_n(cs_n8), .sclk(sclk8),
    .busy(busy8), .data(data8), .valid(valid8), .ready(1'b1), .overrun(overrun8)
  );
  always #5 clk = ~clk;
  always @(negedge cs_n) begin
    bitp = 11;
    sdo  = adc_word[11];
  end
  always @(negedge sclk) if (!cs_n && bitp > 0) begin
    bitp = bitp - 1;
    sdo  = adc_word[bitp];
  end
  always @(negedge clk) begin
    if (!cs_n) low_cnt = low_cnt + 1;
    if (sclk && !sclk_prev) rise_cnt = rise_cnt + 1;
    if (sclk8 && !sclk8_prev) rise8_cnt = rise8_cnt + 1;
    sclk_prev  = sclk;
    sclk8_prev = sclk8;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // mode 0: plain, 1: extra start pulses while busy, 2: ready raised only for the delivery edge
  task automatic convert(input vec_t v, input int mode);
    vec_t e;
    int n;
    @(negedge clk);
    low_cnt  = 0;
    rise_cnt = 0;
    adc_word = v.word;
    ready    = v.rdy;
    start    = 1'b1;
    exp_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cs_n_after_start", cs_n, 0);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
      start = (mode == 1) && (n == 20 || n == 50);
      if (mode == 2 && n == 95) ready = 1'b1;
    end while (busy && n < 200);
    start = 1'b0;
    e = exp_q.pop_front();
    chk("delivery_cycle", n, 96);
    chk("data", data, e.exp_data);
    chk("valid_on_delivery", valid, 1);
    chk("overrun", overrun, e.exp_ovr);
    chk("cs_low_cycles", low_cnt, 96);
    chk("sclk_rises", rise_cnt, 12);
    @(negedge clk);
    chk("valid_after", valid, !ready);
    chk("data_hold", data, e.exp_data);
    chk("cs_n_idle_after", cs_n, 1);
  endtask
  initial begin
    int n;
    vecs[0] = '{12'hA5C, 1'b1, 12'hA5C, 1'b0};
    vecs[1] = '{12'h3C3, 1'b1, 12'h3C3, 1'b0};
    vecs[2] = '{12'h123, 1'b0, 12'h123, 1'b0};
    vecs[3] = '{12'h456, 1'b0, OVR ? 12'h123 : 12'h456, OVR};
    vecs[4] = '{12'h0FF, 1'b0, OVR ? 12'h123 : 12'h0FF, OVR};
    vecs[5] = '{12'h800, 1'b1, 12'h800, OVR};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    for (int i = 0; i < 6; i++) convert(vecs[i], 0);
    convert('{12'h5A3, 1'b0, 12'h5A3, OVR}, 1);
    repeat (3) @(negedge clk);
    chk("ignored_start_cs_n", cs_n, 1);
    chk("ignored_start_busy", busy, 0);
    // abort a transfer half way, with start and ready asserted alongside reset
    @(negedge clk);
    adc_word = 12'hA5C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    reset_n = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    start = 1'b0;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_data", data, 0);
    chk("midrst_overrun", overrun, 0);
    convert('{12'h7FF, 1'b1, 12'h7FF, 1'b0}, 0);
    convert('{12'h123, 1'b0, 12'h123, 1'b0}, 0);
    convert('{12'h456, 1'b0, 12'h456, 1'b0}, 2);
    @(negedge clk);
    rise8_cnt = 0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (busy8 && n < 100);
    chk("w8_delivery_cycle", n, 16);
    chk("w8_data", data8, 8'hFF);
    chk("w8_valid", valid8, 1);
    chk("w8_sclk_rises", rise8_cnt, 8);
    chk("w8_overrun", overrun8, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_spi_reader.md
ADC_SPI_READER -- requirements
Module: adc_spi_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width in bits (legal 1..32).
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period (legal >=1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port sdo  input  1  serial data from ADC, MSB first.
REQ-007 SHALL have port cs_n  output  1  ADC chip select, active-low.
REQ-008 SHALL have port sclk  output  1  serial clock to ADC, idle low.
REQ-009 SHALL have port busy  output  1  high in SETUP and SHIFT.
REQ-010 SHALL have port data  output  DATA_W  last captured sample.
REQ-011 SHALL have port valid  output  1  data holds an unconsumed sample.
REQ-012 SHALL have port ready  input  1  consumer accepts data when valid&&ready.
REQ-013 SHALL have port overrun  output  1  sticky sample-loss flag (see Configuration).

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> SHIFT -> IDLE; all outputs registered.
REQ-015 IDLE: cs_n=1, sclk=0, busy=0; start=1 at edge E0 -> SETUP, cs_n=0 and busy=1 after E0.
REQ-016 start while busy SHALL be ignored (no queueing, no effect on transfer in progress).
REQ-017 SETUP SHALL last CLK_DIV cycles with sclk=0; first sclk rise at edge E0+CLK_DIV.
REQ-018 SHIFT: sclk SHALL toggle every CLK_DIV cycles, producing exactly DATA_W rising edges at E0+CLK_DIV*(1+2k), k=0..DATA_W-1.
REQ-019 At each edge that drives sclk 0->1, sdo SHALL be shifted into the LSB of an internal shift register (first bit ends as MSB).
REQ-020 At edge E0+2*DATA_W*CLK_DIV (final sclk fall): sclk=0, cs_n=1, busy=0, state IDLE, sample delivered per REQ-021..023.
REQ-021 Delivery with valid=0: data<=sample, valid<=1.
REQ-022 Delivery with valid=1 and ready=1 same cycle: old sample accepted, data<=new sample, valid stays 1, overrun unchanged.
REQ-023 Delivery with valid=1 and ready=0: handled per Configuration.
REQ-024 valid&&ready without delivery SHALL clear valid next edge; data SHALL hold value.
REQ-025 start accepted in same cycle as delivery edge SHALL NOT occur (FSM still in SHIFT); start is honoured from next IDLE cycle.
REQ-026 Back-to-back conversions SHALL have cs_n high for at least 1 cycle between transfers.
REQ-027 Internal counters SHALL be sized for CLK_DIV and 2*DATA_W without wrap.

Reset
REQ-028 reset_n=0 at a clk edge SHALL force: IDLE, cs_n=1, sclk=0, busy=0, data=0, valid=0, overrun=0, counters and shift register 0.
REQ-029 Reset mid-conversion SHALL discard partial sample; no valid pulse; reset SHALL dominate start and ready.

Configuration
REQ-030 Macro ADC_READER_OVERRUN_EN SHALL select sample-loss policy.
REQ-031 Defined: on REQ-023 case new sample SHALL be discarded, data retains old sample, overrun<=1, sticky until reset.
REQ-032 Undefined: on REQ-023 case data<=new sample, valid stays 1; overrun SHALL be constant 0.

Verification
REQ-033 Defaults, ready=1, ADC model drives 0xA5C MSB-first on sclk falls -> cs_n low 96 cycles, 12 sclk rises, data=0xA5C, valid high one cycle at E0+96.
REQ-034 start pulsed again at E0+20 and E0+50 -> ignored; exactly one transfer, cs_n single low window of 96 cycles.
REQ-035 ready=0, conversions 0x123 then 0x456 -> without macro data=0x456, overrun=0; with macro data=0x123, overrun=1 until reset.
REQ-036 reset_n low at E0+50 -> next edge cs_n=1, sclk=0, busy=0, valid=0; following start with 0x7FF yields data=0x7FF.
REQ-037 valid=1 with ready=1 on delivery edge of 0x456 -> valid stays 1, data=0x456, overrun=0 in both builds.
REQ-038 DATA_W=8, CLK_DIV=1, sdo=1 constant -> 8 sclk rises, data=0xFF, valid at E0+16.
